// File: rtl/cla_pipe_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead add/subtract unit.
package cla_pipe_pkg;

    localparam int unsigned CLA_WIDTH = 16;
    localparam int unsigned CLA_SEG   = 4;

    typedef struct packed {
        logic                 valid;
        logic [CLA_WIDTH-1:0] opnd_a;
        logic [CLA_WIDTH-1:0] opnd_b;
        logic [CLA_WIDTH-1:0] psum;
        logic                 carry;
        logic                 sign;
        logic                 sub;
        logic                 a_msb;
        logic                 b_msb;
    } cla_stage_t;

    // Signed rule uses operand/result MSBs; unsigned rule is carry (add) or borrow (sub).
    function automatic logic cla_ofl(input logic sign, input logic sub,
                                     input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic cout);
        logic ofl;
        if (sign) begin
            ofl = (a_msb == b_msb) && (s_msb != a_msb);
        end else begin
            ofl = sub ? ~cout : cout;
        end
        return ofl;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead adder with group propagate/generate.
module cla_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           p,
    output logic           g,
    output logic           co
);

    logic [SEG-1:0] pb_c;
    logic [SEG-1:0] gb_c;
    logic [SEG:0]   c_c;
    logic           gg_c;

    assign pb_c = a ^ b;
    assign gb_c = a & b;

    // Each carry is the flat sum-of-products over all lower generate terms and ci.
    always_comb begin
        logic gen_v;
        logic prop_v;
        c_c    = '0;
        c_c[0] = ci;
        gen_v  = 1'b0;
        prop_v = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            gen_v  = 1'b0;
            prop_v = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gen_v  = gen_v | (prop_v & gb_c[j]);
                prop_v = prop_v & pb_c[j];
            end
            c_c[i+1] = gen_v | (prop_v & ci);
        end
        gg_c = gen_v;
    end

    assign s  = pb_c ^ c_c[SEG-1:0];
    assign p  = &pb_c;
    assign g  = gg_c;
    assign co = c_c[SEG];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead add/subtract: one SEG-bit segment resolved per stage,
// valid/ready handshake with whole-pipe stall, flags registered with the final stage.
module cla_pipe
    import cla_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned SEG   = CLA_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int unsigned STAGES = WIDTH / SEG;

    if (((WIDTH % SEG) != 0) || (WIDTH != CLA_WIDTH)) begin : g_bad_cfg
        $error("cla_pipe: WIDTH must be a multiple of SEG and match the package stage width");
    end

    cla_stage_t        stage_q [STAGES];
    cla_stage_t        src_c   [STAGES];
    cla_stage_t        nxt_c   [STAGES];
    cla_stage_t        in_stage_c;
    logic [SEG-1:0]    seg_s_c [STAGES];
    logic [STAGES-1:0] seg_p_c;
    logic [STAGES-1:0] seg_g_c;
    logic [STAGES-1:0] seg_co_c;
    logic              adv_c;
    logic              ofl_q;
    logic              zero_q;
    logic              unused_c;

    assign adv_c    = ~stage_q[STAGES-1].valid | out_ready;
    assign in_ready = adv_c;

    // Subtraction is a + ~b with the carry-in forced high.
    always_comb begin
        in_stage_c        = '0;
        in_stage_c.valid  = in_valid;
        in_stage_c.opnd_a = a;
        in_stage_c.opnd_b = sub ? ~b : b;
        in_stage_c.carry  = sub | ci;
        in_stage_c.sign   = sign;
        in_stage_c.sub    = sub;
        in_stage_c.a_msb  = a[WIDTH-1];
        in_stage_c.b_msb  = in_stage_c.opnd_b[WIDTH-1];
    end

    always_comb begin
        src_c[0] = in_stage_c;
        for (int k = 1; k < STAGES; k++) begin
            src_c[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        cla_seg #(.SEG(SEG)) u_seg (
            .a  (src_c[k].opnd_a[k*SEG +: SEG]),
            .b  (src_c[k].opnd_b[k*SEG +: SEG]),
            .ci (src_c[k].carry),
            .s  (seg_s_c[k]),
            .p  (seg_p_c[k]),
            .g  (seg_g_c[k]),
            .co (seg_co_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_c[k]                   = src_c[k];
            nxt_c[k].psum[k*SEG +: SEG] = seg_s_c[k];
            nxt_c[k].carry             = seg_co_c[k];
        end
    end

    // All stages shift together or hold together; bubbles are never squeezed out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            ofl_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv_c) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= nxt_c[k];
            end
            ofl_q  <= cla_ofl(nxt_c[STAGES-1].sign, nxt_c[STAGES-1].sub,
                              nxt_c[STAGES-1].a_msb, nxt_c[STAGES-1].b_msb,
                              nxt_c[STAGES-1].psum[WIDTH-1], nxt_c[STAGES-1].carry);
            zero_q <= (nxt_c[STAGES-1].psum == '0);
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].psum;
    assign cout      = stage_q[STAGES-1].carry;
    assign ofl       = ofl_q;
    assign zero      = zero_q;

    // Group P/G and the final stage's leftover operand fields have no consumer.
    assign unused_c = ^{seg_p_c, seg_g_c, stage_q[STAGES-1]};

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead add/subtract unit: the next-generation successor to the single-cycle 16-bit CLA used in the execute stage. It accepts one operation per cycle under a valid/ready handshake. Each pipeline stage resolves one SEG-bit segment with a local lookahead block and registers the carry into the next stage. It produces the sum/difference plus signed/unsigned overflow, carry-out and zero flags, and sits between operand fetch and the ALU result mux wherever multi-cycle arithmetic or higher clock rates are needed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 4, bits resolved per stage; STAGES = WIDTH/SEG, which is also the pipeline latency.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation present.
- in_ready  output  1  unit accepts the operation this cycle.
- a, b  input  WIDTH  operands.
- ci  input  1  carry-in; used only when sub=0.
- sub  input  1  1 selects a − b. The unit forms a + ~b with carry-in forced to 1.
- sign  input  1  1 selects two's-complement overflow rule; 0 selects unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1.
- ofl  output  1  overflow per the rule below.
- zero  output  1  sum == 0.

## Operation
- Stage k (0..STAGES−1) holds one register slot with these fields:
  - valid bit
  - remaining operand bits a[WIDTH−1:k·SEG] and b'[WIDTH−1:k·SEG], where b' = sub ? ~b : b
  - completed sum bits [k·SEG−1:0]
  - incoming carry
  - sign, sub, and a[WIDTH−1], b'[WIDTH−1] for the overflow calculation
- Stage 0 captures the operands and its carry-in, which is sub ? 1 : ci.
- Each stage computes its segment with a SEG-bit lookahead adder (P/G per bit, lookahead carries) and passes the sum bits and segment carry to the next stage's register.
- The final stage register drives sum, cout, ofl and zero directly.
- Overflow:
  - sign=1: ofl = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
  - sign=0, sub=0: ofl = cout.
  - sign=0, sub=1: ofl = ~cout (borrow).
- Pipeline advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts forward. A stage with no valid input takes valid=0.
  - When adv=0, all stages hold, including bubbles. There is no bubble compression.
- Throughput is one operation per cycle when out_ready is held at 1.

## Timing
- Reset (asynchronous assert, release synchronous to clk): all valid bits 0, so out_valid=0, in_ready=1. sum, cout, ofl and zero all read 0.
- Latency is exactly STAGES cycles from an accepted input (in_valid & in_ready at edge t) to out_valid=1 after edge t+STAGES−1, assuming no stall.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Same-cycle accept and retire is allowed. With out_valid=1 and out_ready=1, a new input is accepted and the pipeline shifts in the same edge.
- in_valid=0 while adv=1 inserts a bubble.
- Payload fields of invalid stages are don't-care; flag outputs are qualified only by out_valid.
- rst asserted mid-operation discards all in-flight operations immediately, with no partial result emitted.
- SEG = WIDTH degenerates to a single registered stage with latency 1. This configuration must be legal.

## Structure
- Shared package holds:
  - default WIDTH/SEG constants
  - the stage-register struct (valid, opnd_a, opnd_b, psum, carry, sign, sub, a_msb, b_msb)
  - the overflow-select function
- One sub-module, cla_seg #(SEG): combinational SEG-bit lookahead adder. Inputs a, b, ci; outputs s, p, g, co.
- Instantiate it with a generate loop, one per stage.
- Elaboration-time check that WIDTH % SEG == 0.

## Test plan
All scenarios use WIDTH=16, SEG=4 unless noted.
- Basic add: a=0x1234, b=0x1111, ci=0, sub=0, sign=0 → 4 cycles later out_valid=1, sum=0x2345, cout=0, ofl=0, zero=0.
- Signed overflow: a=0x7FFF, b=0x0001, sign=1 → sum=0x8000, ofl=1, cout=0. Same operands with sign=0 → ofl=0.
- Subtract:
  - a=0x0005, b=0x0005, sub=1 → sum=0x0000, zero=1, cout=1, ofl=0 for both sign values.
  - a=0x0003, b=0x0005, sub=1, sign=0 → sum=0xFFFE, ofl=1 (borrow).
- Full carry ripple across all stages: a=0xFFFF, b=0x0000, ci=1 → sum=0x0000, cout=1, zero=1. With sign=0, ofl=1.
- Back-to-back with stall:
  - Issue 6 consecutive adds; hold out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall, the first result is held unchanged, and all 6 results emerge in order with none lost or duplicated.
- Reset mid-flight: assert rst with 3 operations in flight → out_valid=0 and in_ready=1 immediately. After release, no stale results appear. Repeat the basic add with SEG=16 and confirm latency 1.
